iomem_initiator: RTL and testbench
==================================

Name: iomem_initiator

Overview:
- Bus-initiator (master) for the PicoRV32-style iomem interface, i.e. the requesting end of the memory-mapped accelerator register port.
- Accepts queued register commands (address, write data, byte strobes) on a valid/ready stream and issues them one at a time as iomem transactions.
- Returns read data and a timeout error flag on a response stream.
- Used by bench harnesses and non-CPU sequencers to drive accelerator CSRs (0x0300_0000 region) without the core.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, >= 2.
- TIMEOUT, 255, max cycles to wait for iomem_ready; 0 disables the timeout.
- TO_WIDTH, 8, timeout counter width; must satisfy TIMEOUT < 2^TO_WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_addr  in  32  target byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte strobes; 0 = read.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  captured iomem_rdata; 0 on error.
- rsp_err  out  1  transaction timed out.
- iomem_valid  out  1  transaction request.
- iomem_ready  in  1  responder done (single-cycle pulse).
- iomem_addr  out  32  request address.
- iomem_wdata  out  32  request write data.
- iomem_wstrb  out  4  request strobes.
- iomem_rdata  in  32  responder read data.
- busy  out  1  FIFO non-empty or state != IDLE.

Behaviour:
Reset (resetn low at an edge):
- FIFO pointers and count cleared, contents not cleared.
- State IDLE.
- iomem_valid=0; iomem_addr, iomem_wdata, iomem_wstrb = 0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- Reset mid-transaction abandons it: no response is produced, and iomem_valid is low after that edge.

Command FIFO:
- cmd_ready = (count != DEPTH), combinational from registered count.
- Push on cmd_valid && cmd_ready.
- Pop only in IDLE when count != 0.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.

State machine (IDLE, REQ, RSP):
- IDLE
  - If FIFO non-empty: pop the head.
  - Load iomem_addr/wdata/wstrb from the popped entry and set iomem_valid=1 at the same edge.
  - Clear the timeout counter and go to REQ.
- REQ
  - iomem_valid and all request fields hold stable until termination.
  - If iomem_ready=1 at an edge: iomem_valid<=0, rsp_rdata<=iomem_rdata (captured for writes too), rsp_err<=0, rsp_valid<=1, go to RSP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: iomem_valid<=0, rsp_rdata<=0, rsp_err<=1, rsp_valid<=1, go to RSP.
  - Else counter<=counter+1.
  - iomem_ready and timeout at the same edge: ready wins.
- RSP
  - rsp_valid, rsp_rdata and rsp_err hold until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0 and go to IDLE.
  - Next pop no earlier than the following edge, so at most one transaction is outstanding.
- iomem_ready seen outside REQ is ignored.

Latency and timing:
- iomem_valid is deasserted the edge after ready is seen, so a responder gated on "valid && !ready" fires exactly once per transaction.
- Latency with a single-cycle responder and an empty FIFO:
  - cmd accepted at edge T.
  - iomem_valid high after edge T+1.
  - iomem_ready high after edge T+2.
  - rsp_valid high after edge T+3.
- Timeout: iomem_valid is high for exactly TIMEOUT cycles, then rsp_err.

Test Plan:
- Single write: cmd addr=0x0300_0008, wdata=0x0000_0010, wstrb=0xF, responder acks 1 cycle after valid -> iomem_valid high exactly 2 cycles; addr/wdata/wstrb stable; rsp_valid 3 cycles after cmd accept; rsp_err=0.
- Read-back: write 0x0000_0003 to 0x0300_0004, then read (wstrb=0) 0x0300_0004 with responder returning 0x0000_0007 -> two responses in order; second has rsp_rdata=0x0000_0007; iomem_valid drops between transactions.
- FIFO full/back-pressure: rsp_ready=0, push 6 commands with DEPTH=4 -> 1 in flight, 4 queued, cmd_ready=0 from then on; releasing rsp_ready drains all 5 in order; no command lost or duplicated.
- Timeout: TIMEOUT=8, responder never acks -> iomem_valid high exactly 8 cycles, then rsp_err=1, rsp_rdata=0; the next queued command issues normally afterwards.
- Ready at timeout edge: TIMEOUT=8, responder acks on the 8th valid cycle -> rsp_err=0, rsp_rdata=responder data.
- Reset mid-operation: assert resetn=0 while in REQ with 2 commands queued -> next cycle iomem_valid=0, rsp_valid=0, cmd_ready=1, busy=0; no response emitted after reset release.

Source files
------------

// File: rtl/iomem_initiator.sv
// Bus initiator for the PicoRV32-style iomem port: queues register commands in a
// small FIFO and issues them one at a time, returning read data or a timeout flag.
module iomem_initiator #(
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    output logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_EN ? TO_WIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t state_reg, state_next;

    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [3:0]  wstrb_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic                valid_reg, valid_next;
    logic [31:0]         addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [3:0]          wstrb_reg, wstrb_next;
    logic [TO_WIDTH-1:0] to_cnt_reg, to_cnt_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [31:0]         rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;

    logic push, pop;

    assign cmd_ready = (count_reg != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);

    // Storage is left out of reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= cmd_addr;
            wdata_mem[wr_ptr_reg] <= cmd_wdata;
            wstrb_mem[wr_ptr_reg] <= cmd_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next     = state_reg;
        valid_next     = valid_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        to_cnt_next    = to_cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    addr_next   = addr_mem[rd_ptr_reg];
                    wdata_next  = wdata_mem[rd_ptr_reg];
                    wstrb_next  = wstrb_mem[rd_ptr_reg];
                    valid_next  = 1'b1;
                    to_cnt_next = '0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                // A responder ack on the final timeout cycle still counts as success.
                if (iomem_ready) begin
                    valid_next     = 1'b0;
                    rsp_rdata_next = iomem_rdata;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
                    valid_next     = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_WIDTH'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            valid_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            to_cnt_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            valid_reg     <= valid_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            to_cnt_reg    <= to_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign iomem_valid = valid_reg;
    assign iomem_addr  = addr_reg;
    assign iomem_wdata = wdata_reg;
    assign iomem_wstrb = wstrb_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign busy        = (count_reg != '0) || (state_reg != IDLE);
endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator: stimulus queues expected requests and
// responses; a monitor checks iomem requests and response handshakes against them.
module tb_iomem_initiator;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata;
    logic        busy;

    iomem_initiator #(.DEPTH(4), .TIMEOUT(8), .TO_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb),
        .iomem_rdata(iomem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          vlen;
    } req_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    function automatic void check(input bit ok, input string name, input string info);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: %s", name, info);
    endfunction

    // Responder: 0x..F0 never acks, 0x..E0 acks on the 8th valid cycle, others on the 2nd.
    function automatic int ack_at(input logic [31:0] a);
        if (a[7:0] == 8'hF0) return 0;
        if (a[7:0] == 8'hE0) return 8;
        return 2;
    endfunction

    initial begin
        int vcnt;
        vcnt = 0;
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (!iomem_valid) begin
                vcnt = 0;
                iomem_ready = 1'b0;
                iomem_rdata = 32'hDEAD_BEEF;
            end else if (iomem_ready) begin
                iomem_ready = 1'b0;
                iomem_rdata = 32'hDEAD_BEEF;
            end else begin
                vcnt++;
                if (ack_at(iomem_addr) == vcnt) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = {16'h0, iomem_addr[15:0]} + 32'd3;
                end
            end
        end
    end

    // Monitor: request order/fields/stability/length, and response data.
    initial begin
        bit   tracking;
        bit   stable;
        int   vlen;
        req_t cur;
        rsp_t er;
        tracking = 0;
        stable = 1;
        vlen = 0;
        cur = '{32'h0, 32'h0, 4'h0, 0};
        forever begin
            @(negedge clk);
            if (!resetn) begin
                tracking = 0;
            end else begin
                if (iomem_valid) begin
                    if (!tracking) begin
                        tracking = 1;
                        vlen = 0;
                        stable = 1;
                        if (req_q.size() == 0) begin
                            check(0, "unexpected_req", $sformatf("addr=%h issued with nothing pending", iomem_addr));
                            cur = '{iomem_addr, iomem_wdata, iomem_wstrb, -1};
                        end else begin
                            cur = req_q.pop_front();
                            check(iomem_addr == cur.addr && iomem_wdata == cur.wdata && iomem_wstrb == cur.wstrb,
                                  "req_fields", $sformatf("got %h/%h/%h want %h/%h/%h", iomem_addr, iomem_wdata,
                                  iomem_wstrb, cur.addr, cur.wdata, cur.wstrb));
                        end
                    end
                    vlen++;
                    if (iomem_addr != cur.addr || iomem_wdata != cur.wdata || iomem_wstrb != cur.wstrb)
                        stable = 0;
                end else if (tracking) begin
                    tracking = 0;
                    check(vlen == cur.vlen, "valid_len", $sformatf("addr=%h got %0d want %0d cycles", cur.addr, vlen, cur.vlen));
                    check(stable, "req_stable", $sformatf("addr=%h fields changed while valid", cur.addr));
                end
                if (rsp_valid && rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check(0, "unexpected_rsp", $sformatf("rdata=%h err=%b", rsp_rdata, rsp_err));
                    end else begin
                        er = rsp_q.pop_front();
                        check(rsp_rdata == er.rdata && rsp_err == er.err, "rsp",
                              $sformatf("got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, er.rdata, er.err));
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int vl, input logic [31:0] erd, input logic eer);
        logic rdy;
        req_q.push_back('{a, d, s, vl});
        rsp_q.push_back('{erd, eer});
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        cmd_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                cmd_valid = 1'b0;
                $display("cmd accepted addr=%h wdata=%h wstrb=%h", a, d, s);
                return;
            end
        end
        cmd_valid = 1'b0;
        check(0, "cmd_accept", $sformatf("addr=%h not accepted within bound", a));
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(posedge clk);
            #1;
            if (!busy && req_q.size() == 0 && rsp_q.size() == 0) done = 1;
        end
        check(done, name, $sformatf("busy=%b pending req=%0d rsp=%0d", busy, req_q.size(), rsp_q.size()));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit quiet;
        resetn    = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check(!iomem_valid && iomem_addr == 0 && iomem_wdata == 0 && iomem_wstrb == 0, "reset_iomem",
              $sformatf("valid=%b addr=%h wdata=%h wstrb=%h want all 0", iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb));
        check(!rsp_valid && rsp_rdata == 0 && !rsp_err, "reset_rsp",
              $sformatf("valid=%b rdata=%h err=%b want 0", rsp_valid, rsp_rdata, rsp_err));
        check(cmd_ready && !busy, "reset_status", $sformatf("cmd_ready=%b busy=%b want 1/0", cmd_ready, busy));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single write with latency check
        send(32'h0300_0008, 32'h0000_0010, 4'hF, 2, 32'h0000_000B, 1'b0);
        @(posedge clk); #1;
        check(iomem_valid, "lat_valid_T1", $sformatf("iomem_valid=%b want 1", iomem_valid));
        @(posedge clk); #1;
        check(!rsp_valid, "lat_rsp_T2", $sformatf("rsp_valid=%b want 0", rsp_valid));
        @(posedge clk); #1;
        check(rsp_valid, "lat_rsp_T3", $sformatf("rsp_valid=%b want 1", rsp_valid));
        wait_idle("idle_write");

        // Write then read back
        send(32'h0300_0004, 32'h0000_0003, 4'hF, 2, 32'h0000_0007, 1'b0);
        send(32'h0300_0004, 32'h0000_0000, 4'h0, 2, 32'h0000_0007, 1'b0);
        wait_idle("idle_readback");

        // FIFO full under response back-pressure
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(32'h0300_0010 + 32'(4 * i), 32'(i), 4'hF, 2, 32'h13 + 32'(4 * i), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmd_addr  = 32'h0300_0024;
        cmd_wdata = 32'd5;
        cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(!cmd_ready && busy, "full_backpressure", $sformatf("cmd_ready=%b busy=%b want 0/1", cmd_ready, busy));
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        send(32'h0300_0024, 32'd5, 4'hF, 2, 32'h0000_0027, 1'b0);
        wait_idle("idle_drain");

        // Timeout, then a normal command
        send(32'h0300_00F0, 32'h1111_2222, 4'hF, 8, 32'h0, 1'b1);
        send(32'h0300_000C, 32'h0, 4'h0, 2, 32'h0000_000F, 1'b0);
        wait_idle("idle_timeout");

        // Ack on the final timeout cycle
        send(32'h0300_00E0, 32'h0, 4'h0, 8, 32'h0000_00E3, 1'b0);
        wait_idle("idle_ack_at_limit");

        // Reset in the middle of a transaction with two queued
        send(32'h0300_00F0, 32'hA, 4'hF, 8, 32'h0, 1'b1);
        send(32'h0300_0030, 32'hB, 4'hF, 2, 32'h33, 1'b0);
        send(32'h0300_0034, 32'hC, 4'hF, 2, 32'h37, 1'b0);
        @(posedge clk); #1;
        check(iomem_valid && busy, "pre_reset_req", $sformatf("iomem_valid=%b busy=%b want 1/1", iomem_valid, busy));
        resetn = 1'b0;
        req_q.delete();
        rsp_q.delete();
        @(posedge clk); #1;
        check(!iomem_valid && !rsp_valid && cmd_ready && !busy, "mid_reset",
              $sformatf("iomem_valid=%b rsp_valid=%b cmd_ready=%b busy=%b want 0/0/1/0",
              iomem_valid, rsp_valid, cmd_ready, busy));
        resetn = 1'b1;
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || iomem_valid) quiet = 0;
        end
        check(quiet, "post_reset_quiet", "activity seen after reset release");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
